sram: RTL and testbench
=======================

// Module: sram
// PURPOSE
//  Synchronous 1-read/1-write block RAM holding 2**LOGDEPTH lines of WIDTH bits.
//  It is the data array behind the L1 data cache; the cache addresses it as {way, set index}.
//  Writes are masked per WORDSIZE-bit word. Reads are registered with 1-cycle latency.
// PARAMETERS
//  WORDSIZE  64   bits per write-enable lane
//  WIDTH     512  bits per line; must be a multiple of WORDSIZE
//  LOGDEPTH  9    log2(number of lines), giving 512 lines
//  Derived: LANES = WIDTH/WORDSIZE (default 8)
// PORTS
//  clk          in   1         single clock; all sampling on posedge
//  reset        in   1         asynchronous, active-high
//  readAddr     in   LOGDEPTH  line to read
//  readData     out  WIDTH     registered read data
//  writeAddr    in   LOGDEPTH  line to write
//  writeData    in   WIDTH     write data; lane k = writeData[k*WORDSIZE +: WORDSIZE]
//  writeEnable  in   LANES     per-lane write strobe; all zeros = no write
// BEHAVIOUR
//  - Reset (async, active-high): readData goes to 0 immediately and stays 0 while reset is high.
//  - Writes are ignored while reset is high.
//  - Array contents are NOT cleared by reset.
//  - At time 0 the array is zero-initialised, so an unwritten line reads 0.
//  - Write: at posedge, for each k with writeEnable[k]=1, mem[writeAddr] lane k <= writeData lane k.
//    Lanes with writeEnable[k]=0 keep their old value.
//  - Read: at posedge, readData <= mem[readAddr] as it was before that edge's write.
//    Data is valid from the cycle after the address was presented.
//    readData holds its value until the next posedge.
//  - Same-address collision (readAddr==writeAddr, any enable set):
//    the read returns OLD data (read-before-write); new data is visible on the next read.
//  - Read and write to different lines in the same cycle are fully independent.
//  - Address range is exactly 0..2**LOGDEPTH-1; no wrap or out-of-range case exists.
//  - No handshake or busy signal: one read and one write are accepted every cycle.
//  - Addresses and data are don't-care when writeEnable=0. No X may propagate to readData
//    after reset, for any address in range.
//  - Reset released mid-operation: the first posedge after deassertion performs a normal
//    read/write.
//  - Purely behavioural array (reg [WIDTH-1:0] mem[0:2**LOGDEPTH-1]); no tech macros.
// TESTING
//  1) Assert reset with readAddr=5 -> readData=0 asynchronously, before any clk edge.
//     Deassert reset -> readData=0 next cycle (unwritten line).
//  2) Write addr 0x1A3, data {8{64'hDEADBEEF_00000000+k}}, writeEnable=8'hFF; then read 0x1A3
//     -> full line returned exactly 1 cycle after readAddr applied.
//  3) Line 7 = all 0x11..; write 8'h05 mask with 0xFF.. data -> read gives lanes 0,2 = 0xFF..,
//     lanes 1,3-7 = 0x11..
//  4) Same-cycle readAddr=writeAddr=0x40, old=A, new=B -> that read returns A; next read returns B.
//  5) Write line 0x000 and line 0x1FF (boundaries) with distinct data; back-to-back reads of
//     0x1FF, 0x000, 0x1FF -> correct data each cycle, no aliasing.
//  6) Pulse reset during a write cycle with writeEnable=8'hFF -> the line keeps its prior
//     contents; previously written lines survive reset.

Source files
------------

// File: rtl/sram_if.sv
// Bus bundle for the 1R/1W line RAM: one read port and one masked write port.
interface sram_if #(
    parameter int WORDSIZE = 64,
    parameter int WIDTH    = 512,
    parameter int LOGDEPTH = 9
);
    localparam int LANES = WIDTH / WORDSIZE;

    logic [LOGDEPTH-1:0] readAddr;
    logic [WIDTH-1:0]    readData;
    logic [LOGDEPTH-1:0] writeAddr;
    logic [WIDTH-1:0]    writeData;
    logic [LANES-1:0]    writeEnable;

    // Requester side (cache controller)
    modport master (
        output readAddr,
        input  readData,
        output writeAddr,
        output writeData,
        output writeEnable
    );

    // RAM side
    modport slave (
        input  readAddr,
        output readData,
        input  writeAddr,
        input  writeData,
        input  writeEnable
    );
endinterface

// File: rtl/sram.sv
// Synchronous 1-read/1-write line RAM backing the L1 data cache.
// Writes are masked per WORDSIZE-bit lane; reads are registered (1-cycle latency)
// and return the line as it was before the same edge's write (read-before-write).
module sram #(
    parameter int WORDSIZE = 64,
    parameter int WIDTH    = 512,
    parameter int LOGDEPTH = 9
) (
    input  logic   clk,
    input  logic   reset,
    sram_if.slave  bus
);
    localparam int LANES = WIDTH / WORDSIZE;
    localparam int DEPTH = 1 << LOGDEPTH;

    // Zero at power-up so unwritten lines never read as X; reset leaves contents alone.
    logic [WIDTH-1:0] mem [0:DEPTH-1] = '{default: '0};

    logic [WIDTH-1:0] read_data_d;
    logic [WIDTH-1:0] read_data_q;

    // Lane-masked write; suppressed while reset is held.
    always_ff @(posedge clk or posedge reset) begin
        if (!reset) begin
            for (int k = 0; k < LANES; k++) begin
                if (bus.writeEnable[k]) begin
                    mem[bus.writeAddr][k*WORDSIZE +: WORDSIZE] <= bus.writeData[k*WORDSIZE +: WORDSIZE];
                end
            end
        end
    end

    // Next read value is the pre-edge array content, giving read-before-write on collision.
    always_comb begin
        read_data_d = mem[bus.readAddr];
    end

    // Output register; async reset forces readData to zero immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_data_q <= '0;
        end else begin
            read_data_q <= read_data_d;
        end
    end

    assign bus.readData = read_data_q;
endmodule

// File: tb/tb_sram.sv
// Self-checking bench for sram: directed vectors, scoreboard queue + monitor.
module tb_sram;
    localparam int WS = 64;
    localparam int W  = 512;
    localparam int LD = 9;
    localparam int NL = W / WS;

    typedef struct {
        bit         chk;
        logic [W-1:0] exp;
        string      name;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t sb[$];

    sram_if #(.WORDSIZE(WS), .WIDTH(W), .LOGDEPTH(LD)) bus ();

    sram #(.WORDSIZE(WS), .WIDTH(W), .LOGDEPTH(LD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock of stimulus: apply inputs after the falling edge, queue the
    // expected readData that the following rising edge must produce.
    task automatic step(input logic [LD-1:0] ra, input bit chk, input logic [W-1:0] exp,
                        input string name, input logic [LD-1:0] wa,
                        input logic [W-1:0] wd, input logic [NL-1:0] we);
        exp_t e;
        @(negedge clk);
        bus.readAddr    = ra;
        bus.writeAddr   = wa;
        bus.writeData   = wd;
        bus.writeEnable = we;
        e.chk  = chk;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
        @(posedge clk);
    endtask

    // Monitor: every rising edge with a queued entry presents a new readData.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                #1;
                if (e.chk) check(e.name, bus.readData, e.exp);
            end
        end
    end

    logic [W-1:0] l2, l7a, l7b, l7exp, la, lb, lc, ld, le, lf;
    logic [W-1:0] zero;

    initial begin
        checks = 0;
        errors = 0;
        zero   = '0;
        reset  = 1'b0;
        bus.readAddr    = '0;
        bus.writeAddr   = '0;
        bus.writeData   = '0;
        bus.writeEnable = '0;

        for (int k = 0; k < NL; k++) l2[k*WS +: WS] = 64'hDEADBEEF_00000000 + 64'(k);
        l7a   = {NL{64'h1111111111111111}};
        l7b   = {NL{64'hFFFFFFFFFFFFFFFF}};
        l7exp = {{5{64'h1111111111111111}}, 64'hFFFFFFFFFFFFFFFF,
                 64'h1111111111111111, 64'hFFFFFFFFFFFFFFFF};
        la = {NL{64'hAAAA0000AAAA0000}};
        lb = {NL{64'hBBBB1111BBBB1111}};
        lc = {NL{64'h0C0C0C0C0C0C0C0C}};
        ld = {NL{64'hD0D0D0D0D0D0D0D0}};
        le = {NL{64'hEEEE5555EEEE5555}};
        lf = {NL{64'hF00DF00DF00DF00D}};

        // 1) async reset before any clock edge, then unwritten line reads 0
        bus.readAddr = 9'd5;
        #2 reset = 1'b1;
        #1 check("reset_async", bus.readData, zero);
        @(posedge clk); #1 check("reset_hold", bus.readData, zero);
        @(negedge clk); reset = 1'b0;
        step(9'd5, 1, zero, "unwritten_5", 9'd0, '0, 8'h00);

        // 2) full-line write then read with 1-cycle latency
        step(9'd5,   1, zero, "rd5_during_wr", 9'h1A3, l2, 8'hFF);
        step(9'h1A3, 1, l2,   "full_line_1a3", 9'd0,   '0, 8'h00);

        // 3) lane mask 8'h05
        step(9'd0, 0, zero, "wr7a", 9'd7, l7a, 8'hFF);
        step(9'd0, 0, zero, "wr7b", 9'd7, l7b, 8'h05);
        step(9'd7, 1, l7exp, "mask_05_line7", 9'd0, '0, 8'h00);

        // 4) same-address collision: old data first, new data next
        step(9'd0,  0, zero, "wr40a", 9'h40, la, 8'hFF);
        step(9'h40, 1, la,   "collide_old", 9'h40, lb, 8'hFF);
        step(9'h40, 1, lb,   "collide_new", 9'd0,  '0, 8'h00);

        // 5) boundary lines, back-to-back reads
        step(9'd0,   0, zero, "wr000", 9'h000, lc, 8'hFF);
        step(9'd0,   1, lc,   "rd000_after_wr", 9'h1FF, ld, 8'hFF);
        step(9'h1FF, 1, ld,   "rd1ff_a", 9'd0, '0, 8'h00);
        step(9'h000, 1, lc,   "rd000",   9'd0, '0, 8'h00);
        step(9'h1FF, 1, ld,   "rd1ff_b", 9'd0, '0, 8'h00);

        // 6) reset pulsed during a write: line keeps old contents
        step(9'd0,   0, zero, "wr55", 9'h55, le, 8'hFF);
        step(9'h1A3, 1, l2,   "rd1a3_pre_reset", 9'd0, '0, 8'h00);
        @(negedge clk);
        bus.readAddr    = 9'h55;
        bus.writeAddr   = 9'h55;
        bus.writeData   = lf;
        bus.writeEnable = 8'hFF;
        reset = 1'b1;
        #1 check("reset_async_mid", bus.readData, zero);
        @(posedge clk); #1 check("reset_during_wr", bus.readData, zero);
        @(negedge clk);
        bus.writeEnable = 8'h00;
        reset = 1'b0;
        step(9'h55,  1, le,    "line55_survives", 9'd0, '0, 8'h00);
        step(9'h1A3, 1, l2,    "line1a3_survives", 9'd0, '0, 8'h00);
        step(9'd7,   1, l7exp, "line7_survives", 9'd0, '0, 8'h00);
        step(9'h40,  1, lb,    "line40_survives", 9'd0, '0, 8'h00);

        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d pending required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
